wb_skid_stage: RTL and testbench

//  Parametrised MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/wb_slot.sv | 35 +++
 rtl/wb_skid_stage.sv | 164 ++++++++++++++++
 tb/tb_wb_skid_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: writeback entry bundle and skid-stage occupancy encoding.
// Default widths match the RV32 integer register file.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // Encoded so the state value doubles as the entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wb_occ_e;

endpackage

// File: rtl/wb_slot.sv
// One writeback entry register: load enable, x0 write guard, sync clear.
// Used twice by wb_skid_stage (head and skid).
module wb_slot #(
  parameter int XLEN           = 32,
  parameter int RADDR_W        = 5,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ld,
  input  logic               d_we,
  input  logic [RADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]    d_data,
  output logic               q_we,
  output logic [RADDR_W-1:0] q_addr,
  output logic [XLEN-1:0]    q_data
);

  logic guard_hit;

  assign guard_hit = (ZERO_REG_GUARD != 0) && (d_addr == '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      q_we   <= 1'b0;
      q_addr <= '0;
      q_data <= '0;
    end else if (ld) begin
      q_we   <= d_we & ~guard_hit;
      q_addr <= d_addr;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/wb_skid_stage.sv
// MEM->WB register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional WB_FWD_EN adds a combinational forwarding query over held entries.
module wb_skid_stage #(
  parameter int XLEN           = cpu_pkg::XLEN,
  parameter int RADDR_W        = cpu_pkg::REG_ADDR_W,
  parameter int ZERO_REG_GUARD = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_rd_we,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]    in_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_rd_we,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic [XLEN-1:0]    out_rd_data,
`ifdef WB_FWD_EN
  input  logic [RADDR_W-1:0] fwd_addr,
  output logic               fwd_hit,
  output logic [XLEN-1:0]    fwd_data,
`endif
  output logic [1:0]         occupancy
);

  import cpu_pkg::*;

  wb_occ_e state_q, state_d;

  logic accept, pop;
  logic head_ld, skid_ld, head_from_skid;

  logic               head_we, skid_we, hd_we;
  logic [RADDR_W-1:0] skid_addr, hd_addr;
  logic [XLEN-1:0]    skid_data, hd_data;

  // Ready comes from registered state only, breaking the WB->MEM path.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_rd_we = out_valid & head_we;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    skid_ld        = 1'b0;
    head_from_skid = 1'b0;
    if (!flush) begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            head_ld = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_ld = 1'b1;
          end else if (accept) begin
            state_d = TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d        = ONE;
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    hd_we   = in_rd_we;
    hd_addr = in_rd_addr;
    hd_data = in_rd_data;
    unique case (1'b1)
      head_from_skid: begin
        hd_we   = skid_we;
        hd_addr = skid_addr;
        hd_data = skid_data;
      end
      default: ;
    endcase
  end

  wb_slot #(
    .XLEN           (XLEN),
    .RADDR_W        (RADDR_W),
    .ZERO_REG_GUARD (ZERO_REG_GUARD)
  ) u_head (
    .clk    (clk),
    .clr    (rst),
    .ld     (head_ld),
    .d_we   (hd_we),
    .d_addr (hd_addr),
    .d_data (hd_data),
    .q_we   (head_we),
    .q_addr (out_rd_addr),
    .q_data (out_rd_data)
  );

  wb_slot #(
    .XLEN           (XLEN),
    .RADDR_W        (RADDR_W),
    .ZERO_REG_GUARD (ZERO_REG_GUARD)
  ) u_skid (
    .clk    (clk),
    .clr    (rst),
    .ld     (skid_ld),
    .d_we   (in_rd_we),
    .d_addr (in_rd_addr),
    .d_data (in_rd_data),
    .q_we   (skid_we),
    .q_addr (skid_addr),
    .q_data (skid_data)
  );

`ifdef WB_FWD_EN
  logic head_hit, skid_hit;

  assign skid_hit = (state_q == TWO) && skid_we &&
                    (skid_addr == fwd_addr);
  assign head_hit = out_valid && head_we &&
                    (out_rd_addr == fwd_addr);

  // Skid holds the younger entry, so it wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      unique case (1'b1)
        skid_hit: begin
          fwd_hit  = 1'b1;
          fwd_data = skid_data;
        end
        head_hit: begin
          fwd_hit  = 1'b1;
          fwd_data = out_rd_data;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_wb_skid_stage.sv
// Scoreboard bench for wb_skid_stage: directed scenarios then random traffic.
// Define WB_FWD_EN to also check the forwarding query.
module tb_wb_skid_stage;

  import cpu_pkg::*;

  localparam int GUARD = 1;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready, in_rd_we;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_rd_data;
  logic        out_valid, out_ready, out_rd_we;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_data;
  logic [1:0]  occupancy;
  logic [4:0]  fwd_addr;
`ifdef WB_FWD_EN
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;
  wb_entry_t q[$];

  always #5 clk = ~clk;

  wb_skid_stage #(
    .XLEN(32), .RADDR_W(5), .ZERO_REG_GUARD(GUARD)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_we(out_rd_we), .out_rd_addr(out_rd_addr),
    .out_rd_data(out_rd_data),
`ifdef WB_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data),
`endif
    .occupancy(occupancy)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order list of held entries, capacity 2.
  always @(negedge clk) begin
    int n;
    wb_entry_t e;
    if (rst) begin
      q.delete();
    end else begin
      n = q.size();
      chk("occupancy", 64'(occupancy), 64'(n));
      chk("out_valid", 64'(out_valid), 64'(n != 0));
      chk("in_ready", 64'(in_ready), 64'(n < 2));
      if (n != 0) begin
        chk("head_we", 64'(out_rd_we), 64'(q[0].we));
        chk("head_addr", 64'(out_rd_addr), 64'(q[0].addr));
        chk("head_data", 64'(out_rd_data), 64'(q[0].data));
      end else begin
        chk("idle_we", 64'(out_rd_we), 64'd0);
      end
`ifdef WB_FWD_EN
      begin
        logic        eh;
        logic [31:0] ed;
        eh = 1'b0;
        ed = '0;
        for (int i = n - 1; i >= 0; i--)
          if (!eh && fwd_addr != 0 && q[i].we &&
              q[i].addr == fwd_addr) begin
            eh = 1'b1;
            ed = q[i].data;
          end
        chk("fwd_hit", 64'(fwd_hit), 64'(eh));
        chk("fwd_data", 64'(fwd_data), 64'(ed));
      end
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (n != 0 && out_ready) void'(q.pop_front());
        if (in_valid && n < 2) begin
          e.we   = in_rd_we && !(GUARD != 0 && in_rd_addr == 0);
          e.addr = in_rd_addr;
          e.data = in_rd_data;
          q.push_back(e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] a,
                       input logic [31:0] d);
    in_valid   = 1'b1;
    in_rd_we   = we;
    in_rd_addr = a;
    in_rd_data = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    fwd_addr = '0;
    drive(1'b1, 5'd9, 32'h1234_5678);
    repeat (2) cyc();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_data", 64'(out_rd_data), 64'd0);
    chk("rst_addr", 64'(out_rd_addr), 64'd0);
    chk("rst_we", 64'(out_rd_we), 64'd0);

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd5, 32'hA5A5_0001 + 32'(i));
      cyc();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", 64'(out_rd_data),
          64'(32'hA5A5_0001 + 32'(i)));
    end
    in_valid = 1'b0;
    repeat (2) cyc();

    // Backpressure fills both slots.
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'h3333);
    cyc();
    drive(1'b1, 5'd4, 32'h4444);
    cyc();
    in_valid = 1'b0;
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head3", 64'(out_rd_addr), 64'd3);
    out_ready = 1'b1;
    cyc();
    chk("bp_head4", 64'(out_rd_addr), 64'd4);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    cyc();
    chk("bp_occ0", 64'(occupancy), 64'd0);
    out_ready = 1'b0;

    // Flush with both slots full and an input offered.
    drive(1'b1, 5'd10, 32'hAAAA);
    cyc();
    drive(1'b1, 5'd11, 32'hBBBB);
    cyc();
    flush = 1'b1;
    drive(1'b1, 5'd12, 32'hBAD0_0001);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_occ", 64'(occupancy), 64'd0);
    chk("flush2_valid", 64'(out_valid), 64'd0);

    // Flush from one entry drops an acceptable input.
    drive(1'b1, 5'd13, 32'hCCCC);
    cyc();
    flush = 1'b1;
    drive(1'b1, 5'd14, 32'hBAD0_0002);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_occ", 64'(occupancy), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 5'd15, 32'hDDDD);
    cyc();
    in_valid = 1'b0;
    chk("post_flush_data", 64'(out_rd_data), 64'hDDDD);
    cyc();

    // x0 write guard.
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 32'hDEAD_BEEF);
    cyc();
    in_valid = 1'b0;
    chk("guard_valid", 64'(out_valid), 64'd1);
    chk("guard_we", 64'(out_rd_we), 64'd0);
    chk("guard_data", 64'(out_rd_data), 64'hDEAD_BEEF);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

`ifdef WB_FWD_EN
    drive(1'b1, 5'd7, 32'h11);
    cyc();
    drive(1'b1, 5'd7, 32'h22);
    cyc();
    in_valid = 1'b0;
    fwd_addr = 5'd7;
    #1;
    chk("fwd_skid_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_skid_data", 64'(fwd_data), 64'h22);
    fwd_addr = 5'd0;
    #1;
    chk("fwd_zero", 64'(fwd_hit), 64'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rd_we   = ($urandom_range(0, 3) != 0);
      in_rd_addr = 5'($urandom_range(0, 7));
      in_rd_data = $urandom;
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 31) == 0);
      fwd_addr   = 5'($urandom_range(0, 7));
      cyc();
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    chk("drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
